prime_range_scanner: RTL

// - Sequential stage directly downstream of the combinational prime test: scans an

---
 rtl/prime_scan_pkg.sv | 18 +
 rtl/trial_div_step.sv | 33 +++
 rtl/prime_range_scanner.sv | 123 ++++++++++++
 3 files changed

// File: rtl/prime_scan_pkg.sv
// Shared encodings for the prime range scanner: FSM states and trial-division verdicts.
package prime_scan_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    TEST = 3'd1,
    EMIT = 3'd2,
    NEXT = 3'd3,
    DONE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CONT  = 2'd0,
    PRIME = 2'd1,
    COMP  = 2'd2
  } verdict_t;

endpackage

// File: rtl/trial_div_step.sv
// One trial-division step: classifies cand against a single divisor div.
// Combinational; the caller advances div while the verdict is CONT.
module trial_div_step
  import prime_scan_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cand,
  input  logic [WIDTH-1:0] div,
  output verdict_t         verdict
);

  logic [2*WIDTH-1:0] w_sq;
  logic [2*WIDTH-1:0] w_cand_ext;
  logic [WIDTH-1:0]   w_rem;

  // Square is formed at double width so it can never wrap.
  assign w_sq       = {{WIDTH{1'b0}}, div} * {{WIDTH{1'b0}}, div};
  assign w_cand_ext = {{WIDTH{1'b0}}, cand};
  assign w_rem      = cand % div;

  always_comb begin
    verdict = CONT;
    if (cand < WIDTH'(2)) begin
      verdict = COMP;
    end else if (w_sq > w_cand_ext) begin
      verdict = PRIME;
    end else if (w_rem == '0) begin
      verdict = COMP;
    end
  end

endmodule

// File: rtl/prime_range_scanner.sv
// Scans [range_lo, range_hi] by trial division (one divisor per clock) and streams
// each prime out on a valid/ready port, counting handed-off primes.
module prime_range_scanner
  import prime_scan_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   range_lo,
  input  logic [WIDTH-1:0]   range_hi,
  input  logic               prime_ready,
  output logic               prime_valid,
  output logic [WIDTH-1:0]   prime_data,
  output logic [COUNT_W-1:0] prime_count,
  output logic               busy,
  output logic               done
);

  state_t             r_state;
  logic [WIDTH-1:0]   r_cand;
  logic [WIDTH-1:0]   r_div;
  logic [WIDTH-1:0]   r_hi;
  logic               r_valid;
  logic [WIDTH-1:0]   r_data;
  logic [COUNT_W-1:0] r_count;
  logic               r_busy;
  logic               r_done;
  verdict_t           w_verdict;

  trial_div_step #(.WIDTH(WIDTH)) u_step (
    .cand    (r_cand),
    .div     (r_div),
    .verdict (w_verdict)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cand  <= '0;
      r_div   <= '0;
      r_hi    <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != IDLE && abort) begin
        r_state <= IDLE;
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_count <= '0;
              r_busy  <= 1'b1;
              if (range_lo > range_hi) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end else begin
                r_hi    <= range_hi;
                r_cand  <= range_lo;
                r_div   <= WIDTH'(2);
                r_state <= TEST;
              end
            end
          end
          TEST: begin
            case (w_verdict)
              PRIME: begin
                r_valid <= 1'b1;
                r_data  <= r_cand;
                r_state <= EMIT;
              end
              COMP:    r_state <= NEXT;
              default: r_div   <= r_div + WIDTH'(1);
            endcase
          end
          EMIT: begin
            if (prime_ready) begin
              r_valid <= 1'b0;
              if (r_count != '1) r_count <= r_count + COUNT_W'(1);
              r_state <= NEXT;
            end
          end
          NEXT: begin
            // Stopping on cand == hi keeps cand from wrapping past the top value.
            if (r_cand == r_hi) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_cand  <= r_cand + WIDTH'(1);
              r_div   <= WIDTH'(2);
              r_state <= TEST;
            end
          end
          DONE: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign prime_valid = r_valid;
  assign prime_data  = r_data;
  assign prime_count = r_count;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule
